scroll_ctrl: RTL and testbench

Sequences world-scroll steps for the array of rectangle objects. It takes the raw one-hot direction buttons, checks the OR-reduced per-rectangle blocking flags, and issues single-cycle step codes on a shared `btns_o` bus that fans out to every rectangle's `btns` input. It provides press-and-hold auto-repeat with a settle window, so each step is judged against blocking flags that reflect the previous step. It also owns the player colour register that the rectangles compare against.

---
 rtl/scroll_ctrl_if.sv | 34 +++
 rtl/scroll_ctrl.sv | 158 +++++++++++++++
 tb/tb_scroll_ctrl.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/scroll_ctrl_if.sv
// ---------------------------------------------------------------------------
// scroll_ctrl_if : button/blocking inputs and step/colour outputs of scroll_ctrl
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface scroll_ctrl_if #(
    parameter int N_RECT = 8
);
    logic [3:0]        btns;
    logic              color_btn;
    logic [N_RECT-1:0] up_block;
    logic [N_RECT-1:0] down_block;
    logic [N_RECT-1:0] left_block;
    logic [N_RECT-1:0] right_block;
    logic [3:0]        btns_o;
    logic [3:0]        player_color;
    logic              step;
    logic              blocked;
    logic [15:0]       step_cnt;

    // master: the surrounding system that drives buttons and blocking flags
    modport master (
        output btns, color_btn, up_block, down_block, left_block, right_block,
        input  btns_o, player_color, step, blocked, step_cnt
    );

    modport slave (
        input  btns, color_btn, up_block, down_block, left_block, right_block,
        output btns_o, player_color, step, blocked, step_cnt
    );
endinterface

`default_nettype wire

// File: rtl/scroll_ctrl.sv
// ---------------------------------------------------------------------------
// scroll_ctrl : world-scroll step sequencer with hold auto-repeat and colour
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module scroll_ctrl #(
    parameter int SETTLE_CYC  = 2,
    parameter int REPEAT_DLY  = 16,
    parameter int REPEAT_RATE = 4,
    parameter int NUM_COLORS  = 4
) (
    input  wire logic     btnClk,
    input  wire logic     rst,
    scroll_ctrl_if.slave  bus
);

    localparam logic [15:0] C_SETTLE_LD = 16'(SETTLE_CYC - 1);
    localparam logic [15:0] C_DLY_LD    = 16'(REPEAT_DLY - 1);
    localparam logic [15:0] C_RATE_LD   = 16'(REPEAT_RATE - 1);
    localparam logic [3:0]  C_COLOR_MAX = 4'(NUM_COLORS - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_SETTLE = 2'd2,
        S_HOLD   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  dir_q, dir_d;
    logic [15:0] cnt_q, cnt_d;
    logic        rep_q, rep_d;
    logic [3:0]  btns_o_q, btns_o_d;
    logic        step_q, step_d;
    logic        blocked_q, blocked_d;
    logic [15:0] step_cnt_q, step_cnt_d;
    logic [3:0]  player_color_q, player_color_d;
    logic        color_btn_q, color_btn_d;

    logic [3:0]  w_blk_vec;
    logic        w_req_valid;
    logic        w_req_blk;
    logic        w_dir_blk;

    // Bit positions line up with the one-hot codes: 8=up, 4=down, 2=right, 1=left
    assign w_blk_vec   = {|bus.up_block, |bus.down_block, |bus.right_block, |bus.left_block};
    assign w_req_valid = (bus.btns == 4'd8) || (bus.btns == 4'd4) ||
                         (bus.btns == 4'd2) || (bus.btns == 4'd1);
    assign w_req_blk   = |(bus.btns & w_blk_vec);
    assign w_dir_blk   = |(dir_q & w_blk_vec);

    always_comb begin
        state_d        = state_q;
        dir_d          = dir_q;
        cnt_d          = cnt_q;
        rep_d          = rep_q;
        btns_o_d       = 4'd0;
        step_d         = 1'b0;
        blocked_d      = 1'b0;
        step_cnt_d     = step_cnt_q;
        color_btn_d    = bus.color_btn;
        player_color_d = player_color_q;

        if (bus.color_btn && !color_btn_q)
            player_color_d = (player_color_q == C_COLOR_MAX) ? 4'd0 : player_color_q + 4'd1;

        // Outputs are registered, so the step code is loaded on entry to ISSUE
        case (state_q)
            S_IDLE: begin
                if (w_req_valid) begin
                    dir_d = bus.btns;
                    rep_d = 1'b0;
                    if (w_req_blk) begin
                        blocked_d = 1'b1;
                        cnt_d     = C_DLY_LD;
                        state_d   = S_HOLD;
                    end else begin
                        btns_o_d   = bus.btns;
                        step_d     = 1'b1;
                        step_cnt_d = step_cnt_q + 16'd1;
                        state_d    = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                cnt_d   = C_SETTLE_LD;
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                if (cnt_q == 16'd0) begin
                    if (bus.btns != dir_q) begin
                        state_d = S_IDLE;
                    end else begin
                        cnt_d   = rep_q ? C_RATE_LD : C_DLY_LD;
                        state_d = S_HOLD;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_HOLD: begin
                if (bus.btns != dir_q) begin
                    state_d = S_IDLE;
                end else if (cnt_q == 16'd0) begin
                    rep_d = 1'b1;
                    if (w_dir_blk) begin
                        blocked_d = 1'b1;
                        cnt_d     = C_RATE_LD;
                    end else begin
                        btns_o_d   = dir_q;
                        step_d     = 1'b1;
                        step_cnt_d = step_cnt_q + 16'd1;
                        state_d    = S_ISSUE;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge btnClk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            dir_q          <= 4'd0;
            cnt_q          <= 16'd0;
            rep_q          <= 1'b0;
            btns_o_q       <= 4'd0;
            step_q         <= 1'b0;
            blocked_q      <= 1'b0;
            step_cnt_q     <= 16'd0;
            player_color_q <= 4'd0;
            color_btn_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            dir_q          <= dir_d;
            cnt_q          <= cnt_d;
            rep_q          <= rep_d;
            btns_o_q       <= btns_o_d;
            step_q         <= step_d;
            blocked_q      <= blocked_d;
            step_cnt_q     <= step_cnt_d;
            player_color_q <= player_color_d;
            color_btn_q    <= color_btn_d;
        end
    end

    assign bus.btns_o       = btns_o_q;
    assign bus.step         = step_q;
    assign bus.blocked      = blocked_q;
    assign bus.step_cnt     = step_cnt_q;
    assign bus.player_color = player_color_q;

endmodule

`default_nettype wire

// File: tb/tb_scroll_ctrl.sv
// ---------------------------------------------------------------------------
// tb_scroll_ctrl : directed self-checking bench for scroll_ctrl
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_scroll_ctrl;

    logic btnClk;
    logic rst;
    int   n_assert;
    int   n_fail;

    scroll_ctrl_if #(.N_RECT(8)) bus ();

    scroll_ctrl #(
        .SETTLE_CYC (2),
        .REPEAT_DLY (16),
        .REPEAT_RATE(4),
        .NUM_COLORS (4)
    ) dut (
        .btnClk(btnClk),
        .rst   (rst),
        .bus   (bus.slave)
    );

    initial btnClk = 1'b0;
    always #5 btnClk = ~btnClk;

    task automatic tick();
        @(posedge btnClk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    function automatic bit rep_slot(input int i);
        return (i == 1) || (i >= 20 && ((i - 20) % 7) == 0);
    endfunction

    initial begin
        int steps_seen;
        int blk_seen;
        int waited;
        bit found;

        n_assert = 0;
        n_fail   = 0;
        rst             = 1'b1;
        bus.btns        = 4'd0;
        bus.color_btn   = 1'b0;
        bus.up_block    = 8'd0;
        bus.down_block  = 8'd0;
        bus.left_block  = 8'd0;
        bus.right_block = 8'd0;

        // Reset state
        #2;
        check("rst_btns_o",  bus.btns_o, 0);
        check("rst_step",    bus.step, 0);
        check("rst_blocked", bus.blocked, 0);
        check("rst_cnt",     bus.step_cnt, 0);
        check("rst_color",   bus.player_color, 0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Single tap right
        bus.btns = 4'd2;
        tick();
        bus.btns = 4'd0;
        check("tap_btns_o", bus.btns_o, 2);
        check("tap_step",   bus.step, 1);
        check("tap_cnt",    bus.step_cnt, 1);
        steps_seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            steps_seen += int'(bus.step);
            check("tap_quiet_btns_o", bus.btns_o, 0);
        end
        check("tap_extra_steps", steps_seen, 0);
        check("tap_cnt_final", bus.step_cnt, 1);

        // Hold down for 60 cycles: steps at 1, 20, 27, ..., 55
        bus.btns = 4'd4;
        steps_seen = 0;
        for (int i = 1; i <= 60; i++) begin
            tick();
            steps_seen += int'(bus.step);
            check("hold_step",    bus.step, rep_slot(i) ? 1 : 0);
            check("hold_btns_o",  bus.btns_o, rep_slot(i) ? 4 : 0);
            check("hold_blocked", bus.blocked, 0);
        end
        bus.btns = 4'd0;
        for (int i = 0; i < 8; i++) begin
            tick();
            steps_seen += int'(bus.step);
        end
        check("hold_steps", steps_seen, 7);
        check("hold_cnt",   bus.step_cnt, 8);

        // Blocked up, then unblock while held
        bus.up_block = 8'b0000_0100;
        bus.btns     = 4'd8;
        tick();
        check("blk_pulse",   bus.blocked, 1);
        check("blk_nostep",  bus.step, 0);
        check("blk_btns_o",  bus.btns_o, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("blk_hold_blocked", bus.blocked, 0);
            check("blk_hold_step",    bus.step, 0);
        end
        bus.up_block = 8'd0;
        found    = 1'b0;
        waited   = 0;
        blk_seen = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            waited++;
            blk_seen += int'(bus.blocked);
            if (bus.step) found = 1'b1;
        end
        check("blk_release_found", found, 1);
        check("blk_release_wait",  waited, 11);
        check("blk_release_code",  bus.btns_o, 8);
        check("blk_no_repulse",    blk_seen, 0);
        bus.btns = 4'd0;
        for (int i = 0; i < 6; i++) tick();
        check("blk_cnt", bus.step_cnt, 9);

        // Invalid multi-hot input, then a valid left press
        bus.btns = 4'b1010;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("inv_btns_o",  bus.btns_o, 0);
            check("inv_step",    bus.step, 0);
            check("inv_blocked", bus.blocked, 0);
        end
        bus.btns = 4'd1;
        tick();
        bus.btns = 4'd0;
        check("inv_then_left", bus.btns_o, 1);
        check("inv_then_step", bus.step, 1);
        tick();
        check("no_back_to_back", bus.btns_o, 0);
        for (int i = 0; i < 5; i++) tick();
        check("inv_cnt", bus.step_cnt, 10);

        // Colour wrap over four rising edges
        for (int k = 1; k <= 4; k++) begin
            bus.color_btn = 1'b1;
            tick();
            check("color_step", bus.player_color, k % 4);
            bus.color_btn = 1'b0;
            tick();
            check("color_hold_low", bus.player_color, k % 4);
        end
        bus.color_btn = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("color_level_once", bus.player_color, 1);
        bus.color_btn = 1'b0;
        tick();
        check("color_after_release", bus.player_color, 1);

        // Reset asserted mid-ISSUE
        bus.btns = 4'd2;
        tick();
        check("pre_rst_issue", bus.btns_o, 2);
        #1;
        rst = 1'b1;
        #1;
        check("async_rst_btns_o", bus.btns_o, 0);
        check("async_rst_step",   bus.step, 0);
        check("async_rst_cnt",    bus.step_cnt, 0);
        check("async_rst_color",  bus.player_color, 0);
        bus.btns = 4'd0;
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_btns_o", bus.btns_o, 0);
        bus.btns = 4'd1;
        tick();
        bus.btns = 4'd0;
        check("post_rst_idle_step", bus.btns_o, 1);
        check("post_rst_cnt",       bus.step_cnt, 1);
        for (int i = 0; i < 5; i++) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
